// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel format and frame-reader state encoding.
package vga_pkg;

    localparam int H_VISIBLE     = 640;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int H_BACK_PORCH  = 48;
    localparam int V_VISIBLE     = 480;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;
    localparam int V_BACK_PORCH  = 33;

    localparam int FRAME_PIXELS  = H_VISIBLE * V_VISIBLE;
    localparam int PIXEL_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with a registered head-of-queue output (first-word fall-through).
// Flush has priority over push and pop in the same cycle.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = PIXEL_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [WIDTH-1:0] head;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == {CNT_W{1'b0}});
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);
    assign pop_data   = head;

    // Storage array, no reset so it maps onto RAM primitives
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the head register that feeds the stream output
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= {PTR_W{1'b0}};
            wr_ptr <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
            head   <= {WIDTH{1'b0}};
        end else if (flush) begin
            rd_ptr <= {PTR_W{1'b0}};
            wr_ptr <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A push lands in the head register when it becomes the oldest entry
            if (do_push && ((count == {CNT_W{1'b0}}) || ((count == CNT_W'(1)) && do_pop))) begin
                head <= push_data;
            end else if (do_pop && (count > CNT_W'(1))) begin
                head <= mem[rd_ptr_inc];
            end
        end
    end

endmodule

// File: rtl/framebuffer_reader.sv
// Streams one frame of pixels from memory to AXI-Stream, throttling reads by FIFO credit
// and discarding responses that belong to a frame abandoned by a new frame sync.
module framebuffer_reader
    import vga_pkg::*;
#(
    parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS,
    parameter int FIFO_DEPTH   = 64,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [ADDR_WIDTH-1:0]  i_Frame_Base,
    input  logic                   i_mm2s_fsync,
    output logic [ADDR_WIDTH-1:0]  o_Read_Addr,
    output logic                   o_Read_Valid,
    input  logic                   i_Read_Ready,
    input  logic [PIXEL_WIDTH-1:0] i_Read_Data,
    input  logic                   i_Read_Data_Valid,
    output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   o_Underflow
);

    localparam int IDX_W = $clog2(FRAME_PIXELS + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_INDEX   = IDX_W'(FRAME_PIXELS - 1);
    localparam logic [IDX_W-1:0] INDEX_END    = IDX_W'(FRAME_PIXELS);
    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    fb_state_t             state;
    fb_state_t             state_next;
    logic                  fsync_prev;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] base_next;
    logic [IDX_W-1:0]      index;
    logic [IDX_W-1:0]      index_next;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_next;
    logic [CNT_W-1:0]      discard;
    logic [CNT_W-1:0]      discard_next;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      fifo_count_next;
    logic [CNT_W:0]        credit_used;
    logic                  read_valid;
    logic                  read_valid_next;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [ADDR_WIDTH-1:0] read_addr_next;
    logic                  frame_start;
    logic                  req_fire;
    logic                  resp_drop;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PIXEL_WIDTH-1:0] fifo_data;

    assign frame_start = i_mm2s_fsync && !fsync_prev;
    assign req_fire    = read_valid && i_Read_Ready;
    assign resp_drop   = i_Read_Data_Valid && (discard != {CNT_W{1'b0}});
    assign fifo_push   = i_Read_Data_Valid && (discard == {CNT_W{1'b0}}) && !fifo_full;
    assign fifo_pop    = !fifo_empty && m_axis_tready;

    assign o_Read_Valid  = read_valid;
    assign o_Read_Addr   = read_addr;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_data;
    assign o_Underflow   = (state != ST_IDLE) && m_axis_tready && fifo_empty;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_WIDTH)
    ) u_fifo (
        .clk       (i_Clock),
        .reset     (i_Reset),
        .push      (fifo_push),
        .push_data (i_Read_Data),
        .pop       (fifo_pop),
        .flush     (frame_start),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame-control state register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next frame-control state; a frame start overrides every other transition
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            ST_FETCH: begin
                if (req_fire && (index == LAST_INDEX)) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if ((outstanding == {CNT_W{1'b0}}) && fifo_empty) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (frame_start) begin
            state_next = ST_FETCH;
        end else begin
            state_next = state_next;
        end
    end

    // Counter updates and the next read request, so the read port is driven from flops
    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !i_Read_Data_Valid) begin
            outstanding_next = outstanding + CNT_W'(1);
        end else if (!req_fire && i_Read_Data_Valid) begin
            outstanding_next = outstanding - CNT_W'(1);
        end else begin
            outstanding_next = outstanding;
        end

        fifo_count_next = fifo_count;
        if (frame_start) begin
            fifo_count_next = {CNT_W{1'b0}};
        end else if (fifo_push && !fifo_pop) begin
            fifo_count_next = fifo_count + CNT_W'(1);
        end else if (!fifo_push && fifo_pop) begin
            fifo_count_next = fifo_count - CNT_W'(1);
        end else begin
            fifo_count_next = fifo_count;
        end

        // Everything still in flight at frame start belongs to the old frame
        discard_next = discard;
        if (frame_start) begin
            discard_next = outstanding_next;
        end else if (resp_drop) begin
            discard_next = discard - CNT_W'(1);
        end else begin
            discard_next = discard;
        end

        index_next = index;
        base_next  = base;
        if (frame_start) begin
            index_next = {IDX_W{1'b0}};
            base_next  = i_Frame_Base;
        end else if (req_fire) begin
            index_next = index + IDX_W'(1);
        end else begin
            index_next = index;
        end

        credit_used     = {1'b0, outstanding_next} + {1'b0, fifo_count_next};
        read_valid_next = (state_next == ST_FETCH) && (credit_used < CREDIT_LIMIT)
                          && (index_next < INDEX_END);
        read_addr_next  = base_next + ADDR_WIDTH'({index_next, 1'b0});
    end

    // Counters, latched base and registered read-port outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            fsync_prev  <= 1'b0;
            base        <= {ADDR_WIDTH{1'b0}};
            index       <= {IDX_W{1'b0}};
            outstanding <= {CNT_W{1'b0}};
            discard     <= {CNT_W{1'b0}};
            read_valid  <= 1'b0;
            read_addr   <= {ADDR_WIDTH{1'b0}};
        end else begin
            fsync_prev  <= i_mm2s_fsync;
            base        <= base_next;
            index       <= index_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            read_valid  <= read_valid_next;
            read_addr   <= read_addr_next;
        end
    end

endmodule

// File: tb/tb_framebuffer_reader.sv
// Randomized directed bench for framebuffer_reader: a latency-modelled memory plus a
// frame-level reference model of which pixels must reach the stream and when reads are allowed.
module tb_framebuffer_reader;

    localparam int FP    = 8;
    localparam int DEPTH = 4;

    logic        clk;
    logic        i_Reset;
    logic [31:0] i_Frame_Base;
    logic        i_mm2s_fsync;
    logic [31:0] o_Read_Addr;
    logic        o_Read_Valid;
    logic        i_Read_Ready;
    logic [15:0] i_Read_Data;
    logic        i_Read_Data_Valid;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        o_Underflow;

    framebuffer_reader #(
        .FRAME_PIXELS (FP),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_WIDTH   (32)
    ) dut (
        .i_Clock           (clk),
        .i_Reset           (i_Reset),
        .i_Frame_Base      (i_Frame_Base),
        .i_mm2s_fsync      (i_mm2s_fsync),
        .o_Read_Addr       (o_Read_Addr),
        .o_Read_Valid      (o_Read_Valid),
        .i_Read_Ready      (i_Read_Ready),
        .i_Read_Data       (i_Read_Data),
        .i_Read_Data_Valid (i_Read_Data_Valid),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .o_Underflow       (o_Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_addr;
        int          frame;
        int          due;
    } req_t;

    int checks = 0;
    int errors = 0;

    // memory model and stimulus knobs
    req_t pending[$];
    int   cyc = 0;
    int   lat_fixed = 3;
    bit   lat_rand = 1'b0;
    bit   rdy_fixed = 1'b1;
    bit   rdy_rand = 1'b0;
    bit   trdy_fixed = 1'b1;
    bit   trdy_rand = 1'b0;

    // reference model: frame-level view of the reader
    logic [15:0] exp_q[$];
    int          cur_frame = 0;
    bit          active = 1'b0;
    bit          fetching = 1'b0;
    bit          fresh = 1'b1;
    bit          fsync_prev = 1'b0;
    int          issued = 0;
    logic [31:0] base = 32'h0;
    int          frame_pops = 0;
    int          uf_count = 0;

    function automatic logic [15:0] pix(input logic [31:0] a);
        return a[16:1] ^ 16'h5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_rv;
        exp_rv = fetching && (issued < FP) && ((pending.size() + exp_q.size()) < DEPTH);
        chk("read_valid", 32'(o_Read_Valid), 32'(exp_rv));
        if (exp_rv) chk("read_addr", o_Read_Addr, base + 32'(2 * issued));
        chk("tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("tdata", 32'(m_axis_tdata), 32'(exp_q[0]));
        chk("underflow", 32'(o_Underflow),
            32'(active && m_axis_tready && (exp_q.size() == 0)));
        if (fresh) begin
            chk("reset_addr", o_Read_Addr, 32'h0);
            chk("reset_tdata", 32'(m_axis_tdata), 32'h0);
        end
    endtask

    task automatic drive_inputs();
        i_Read_Ready  = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        m_axis_tready = trdy_rand ? ($urandom_range(0, 1) == 1) : trdy_fixed;
        if ((pending.size() > 0) && (pending[0].due <= cyc)) begin
            i_Read_Data_Valid = 1'b1;
            i_Read_Data       = pix(pending[0].addr);
        end else begin
            i_Read_Data_Valid = 1'b0;
            i_Read_Data       = 16'($urandom);
        end
    endtask

    // one clock: check at negedge, advance memory and model at posedge, drive after
    task automatic cycle();
        bit          hs;
        bit          pop;
        bit          resp;
        bit          fs;
        bit          drain_done;
        logic [31:0] hs_addr;
        req_t        r;
        @(negedge clk);
        check_outputs();
        hs      = o_Read_Valid && i_Read_Ready;
        hs_addr = o_Read_Addr;
        pop     = m_axis_tvalid && m_axis_tready;
        resp    = i_Read_Data_Valid;
        fs      = i_mm2s_fsync && !fsync_prev;
        if (o_Underflow) uf_count++;
        @(posedge clk);
        if (i_Reset) begin
            pending.delete();
            exp_q.delete();
            active = 1'b0; fetching = 1'b0; fresh = 1'b1;
            fsync_prev = 1'b0; issued = 0; base = 32'h0;
        end else begin
            drain_done = active && !fetching && (pending.size() == 0) && (exp_q.size() == 0);
            if (resp && (pending.size() > 0)) begin
                r = pending.pop_front();
                if ((r.frame == cur_frame) && !fs) begin
                    checks++;
                    assert (exp_q.size() < DEPTH) else begin
                        errors++;
                        $error("FAIL fifo_overflow observed=%0d expected=<%0d", exp_q.size(), DEPTH);
                    end
                    if (pop && (exp_q.size() > 0)) begin
                        void'(exp_q.pop_front());
                        frame_pops++;
                        pop = 1'b0;
                    end
                    exp_q.push_back(pix(r.exp_addr));
                end
            end
            if (pop && !fs && (exp_q.size() > 0)) begin
                void'(exp_q.pop_front());
                frame_pops++;
            end
            if (hs) begin
                r.addr     = hs_addr;
                r.exp_addr = base + 32'(2 * issued);
                r.frame    = cur_frame;
                r.due      = cyc + (lat_rand ? int'($urandom_range(1, 8)) : lat_fixed);
                pending.push_back(r);
                issued++;
                if (issued == FP) fetching = 1'b0;
            end
            if (drain_done && !fs) active = 1'b0;
            if (fs) begin
                cur_frame++;
                exp_q.delete();
                base = i_Frame_Base; issued = 0;
                fetching = 1'b1; active = 1'b1; fresh = 1'b0;
                frame_pops = 0;
            end
            fsync_prev = i_mm2s_fsync;
        end
        cyc++;
        #1;
        drive_inputs();
    endtask

    task automatic start_frame(input logic [31:0] b);
        i_Frame_Base = b;
        i_mm2s_fsync = 1'b1;
        cycle();
        i_mm2s_fsync = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cycles, input string tag);
        for (int n = 0; (n < max_cycles) && active; n++) cycle();
        checks++;
        assert (!active) else begin
            errors++;
            $error("FAIL %s observed=busy expected=idle", tag);
        end
    endtask

    initial begin
        i_Reset = 1'b1; i_Frame_Base = 32'h0; i_mm2s_fsync = 1'b0;
        i_Read_Ready = 1'b0; i_Read_Data = 16'h0; i_Read_Data_Valid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) cycle();
        i_Reset = 1'b0;
        repeat (3) cycle();

        // basic frame, latency 3, no backpressure
        lat_fixed = 3;
        start_frame(32'h0000_1000);
        run_until_idle(100, "basic_idle");
        chk("basic_pixels", 32'(frame_pops), 32'(FP));

        // fsync held for 4 cycles starts one frame; base wraps past 2^32
        lat_fixed = 2;
        i_Frame_Base = 32'hFFFF_FFF8;
        i_mm2s_fsync = 1'b1;
        repeat (4) cycle();
        i_mm2s_fsync = 1'b0;
        run_until_idle(100, "longsync_idle");
        chk("longsync_pixels", 32'(frame_pops), 32'(FP));

        // consumer stalled: credit must stop requests, tdata must hold
        trdy_fixed = 1'b0;
        start_frame(32'h0000_4000);
        repeat (30) cycle();
        chk("bp_fifo_full", 32'(m_axis_tvalid), 32'h1);
        trdy_fixed = 1'b1;
        run_until_idle(100, "bp_idle");
        chk("bp_pixels", 32'(frame_pops), 32'(FP));

        // restart with exactly 3 reads in flight
        lat_fixed = 8;
        start_frame(32'h0000_5000);
        for (int n = 0; (n < 20) && (pending.size() < 3); n++) cycle();
        chk("restart_inflight", 32'(pending.size()), 32'd3);
        i_Read_Ready = 1'b0;
        start_frame(32'h0000_6000);
        run_until_idle(200, "restart_idle");
        chk("restart_pixels", 32'(frame_pops), 32'(FP));

        // long memory latency starves the stream
        lat_fixed = 20;
        uf_count = 0;
        start_frame(32'h0000_7000);
        run_until_idle(300, "uflow_idle");
        chk("uflow_seen", 32'(uf_count > 0), 32'h1);
        uf_count = 0;
        repeat (5) cycle();
        chk("uflow_idle_none", 32'(uf_count), 32'h0);

        // reset while draining
        lat_fixed = 10;
        start_frame(32'h0000_8000);
        for (int n = 0; (n < 100) && fetching; n++) cycle();
        chk("drain_reached", 32'(active && !fetching), 32'h1);
        i_Reset = 1'b1;
        cycle();
        i_Reset = 1'b0;
        repeat (3) cycle();

        // random traffic with random restarts
        lat_rand = 1'b1; rdy_rand = 1'b1; trdy_rand = 1'b1;
        for (int n = 0; n < 600; n++) begin
            i_mm2s_fsync = ($urandom_range(0, 29) == 0);
            i_Frame_Base = $urandom & 32'hFFFF_FFFE;
            cycle();
        end
        i_mm2s_fsync = 1'b0;
        lat_rand = 1'b0; rdy_rand = 1'b0; trdy_rand = 1'b0;
        lat_fixed = 2;
        run_until_idle(300, "random_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/framebuffer_reader.md
# framebuffer_reader

Streams one frame of 16-bit pixels from memory to the VGA output stage over AXI-Stream. Sits directly upstream of the VGA output block:
- consumes that block's frame-sync pulse;
- issues sequential pixel reads to the memory read port;
- buffers returned data in a local FIFO;
- presents pixels on an AXI-Stream master port.

Credit-based request throttling guarantees the FIFO never overflows. Stale reads are discarded when a new frame starts.

## Interface
Parameters:
- FRAME_PIXELS, 307200: pixels per frame (640×480).
- FIFO_DEPTH, 64: pixel FIFO entries; power of two, ≥4.
- ADDR_WIDTH, 32: memory byte-address width.

Ports (one clock; reset is synchronous and active-high):
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Frame_Base  in  ADDR_WIDTH  byte address of pixel 0; sampled at frame start.
- i_mm2s_fsync  in  1  frame sync from VGA output; level, may stay high several cycles.
- o_Read_Addr  out  ADDR_WIDTH  read byte address.
- o_Read_Valid  out  1  read request valid.
- i_Read_Ready  in  1  memory accepts request.
- i_Read_Data  in  16  returned pixel.
- i_Read_Data_Valid  in  1  returned pixel valid; in order; no backpressure.
- m_axis_tdata  out  16  pixel.
- m_axis_tvalid  out  1  pixel valid.
- m_axis_tready  in  1  consumer ready.
- o_Underflow  out  1  one-cycle pulse: tready high, tvalid low, while a frame is active.

## Operation
- States:
  - IDLE: no requests.
  - FETCH: issuing reads.
  - DRAIN: all reads issued, waiting for FIFO empty and zero outstanding.
- Frame start is the rising edge of i_mm2s_fsync, taken against a registered copy of it.
  - In any state, frame start:
    - flushes the FIFO;
    - latches i_Frame_Base;
    - clears the pixel index;
    - loads the discard counter with the current outstanding-read count;
    - enters FETCH.
- Request rule:
  - Request handshake: o_Read_Valid && i_Read_Ready.
  - o_Read_Valid = (state==FETCH) && (outstanding + fifo_count < FIFO_DEPTH) && (index < FRAME_PIXELS).
  - o_Read_Addr = base + 2×index.
  - index increments on each handshake.
  - Once asserted, o_Read_Valid and o_Read_Addr stay stable until the handshake, unless a frame start occurs.
- Outstanding counter: +1 on request handshake, −1 on i_Read_Data_Valid. When both occur, it is unchanged.
- Discarding stale data:
  - i_Read_Data_Valid with discard counter >0 decrements the discard counter; the data is dropped.
  - Otherwise the data is pushed into the FIFO.
  - Discarded responses also decrement outstanding.
  - Credit accounting treats discarded responses as outstanding, so they still consume credit.
- Transitions:
  - FETCH→DRAIN when the last request (index = FRAME_PIXELS−1) handshakes.
  - DRAIN→IDLE when outstanding==0 and the FIFO is empty.
- AXI rules:
  - m_axis_tvalid = FIFO not empty.
  - Pop on tvalid && tready.
  - tdata stays stable while tvalid is high and tready is low.
- Push and pop in the same cycle are both honoured; fifo_count is unchanged.
- Full FIFO: the credit rule makes push-when-full impossible. The bench asserts this never occurs.
- Width rules:
  - Counter widths are $clog2(FRAME_PIXELS+1), $clog2(FIFO_DEPTH+1).
  - Address arithmetic is modulo 2^ADDR_WIDTH.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - o_Read_Valid 0; o_Read_Addr 0.
  - m_axis_tvalid 0; m_axis_tdata 0.
  - o_Underflow 0.
- Frame start: fsync rises in cycle N; o_Read_Valid is high in cycle N+1 with address = base.
- FIFO latency: i_Read_Data_Valid in cycle t gives m_axis_tvalid high in cycle t+1, when the FIFO was empty.
- Frame start coinciding with a request handshake: the handshake counts toward outstanding before the discard counter is loaded.
- Frame start coinciding with a read response:
  - That response is consumed before the discard counter is loaded, as a push or discard under the pre-flush discard count.
  - A pushed pixel is lost in the same-cycle flush.
- Frame start coinciding with a pop: the flush wins.
- Reset mid-frame clears everything, including the discard count. The memory port is reset in the same cycle by system design.

## Structure
- Shared package vga_pkg:
  - VGA timing constants (visible 640/480, porches, sync widths);
  - derived FRAME_PIXELS;
  - the pixel width of 16.
- Sub-module pixel_fifo: synchronous FIFO, FIFO_DEPTH×16.
  - Ports: push, pop, flush, full, empty, count.
  - Distributed/BRAM-inferable memory with registered output.
- Top level holds the FSM, index, outstanding and discard counters.

## Test plan
- Basic frame: FRAME_PIXELS=8, base 0x1000, memory latency 3, tready always 1. Expect addresses 0x1000..0x100E, 8 pixels in order, then IDLE.
- Backpressure: tready held 0 with FIFO_DEPTH=4. Expect at most 4 requests outstanding plus buffered. tvalid/tdata stay stable; no requests while credit is exhausted.
- Restart: fsync rises with 3 reads in flight. Expect those 3 responses dropped, FIFO empty, and the next request at the new base.
- Long fsync: fsync high for 4 cycles. Expect exactly one frame start.
- Underflow: memory latency 20, tready 1 in FETCH. Expect o_Underflow pulses each starved cycle and none in IDLE.
- Reset mid-DRAIN: all outputs return to reset values in the next cycle.
